can_id_extractor: RTL and testbench



---
 rtl/can_id_extractor.sv | 184 ++++++++++++++++++
 tb/tb_can_id_extractor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_id_extractor.sv
// -----------------------------------------------------------------------------
// can_id_extractor
//
// Front end for the CAN acceptance filter. Consumes one sampled bus level per
// nominal bit (qualified by bit_strobe), integrates onto the bus, detects SOF,
// removes stuff bits over the arbitration field (SOF .. IDE) and hands each
// base-format identifier to the filter as a single-cycle id_valid pulse.
// Extended frames and stuff violations are reported with their own pulses and
// never produce an identifier.
//
// Parameters
//   IDLE_BITS   consecutive recessive bits that declare the bus idle
//   CNT_W       width of the accepted-frame counter
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   bit_strobe   one-cycle pulse per bit sample point; qualifies rx_bit
//   rx_bit       sampled bus level (0 = dominant, 1 = recessive)
//   id_out       identifier of the last base frame (ID10 is bit 10)
//   rtr_out      RTR bit of the last base frame
//   id_valid     one-cycle pulse; id_out/rtr_out just updated
//   ext_frame    one-cycle pulse; IDE=1 seen, frame ignored
//   stuff_err    one-cycle pulse; six equal bits inside the de-stuffed region
//   bus_idle     high while the bus is idle (waiting for SOF)
//   frame_count  number of id_valid pulses, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module can_id_extractor #(
    parameter int IDLE_BITS = 11,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_strobe,
    input  logic             rx_bit,
    output logic [10:0]      id_out,
    output logic             rtr_out,
    output logic             id_valid,
    output logic             ext_frame,
    output logic             stuff_err,
    output logic             bus_idle,
    output logic [CNT_W-1:0] frame_count
);

    // Wide enough to hold IDLE_BITS itself.
    localparam int REC_W = $clog2(IDLE_BITS + 1);

    // Field positions counted in de-stuffed data bits after SOF.
    localparam logic [3:0] FLD_ID_LAST = 4'd10;
    localparam logic [3:0] FLD_RTR     = 4'd11;

    // Five equal bits force the next bit on the wire to be a stuff bit.
    localparam logic [2:0] STUFF_RUN = 3'd5;

    typedef enum logic [1:0] {
        ST_INTEGRATE,
        ST_IDLE,
        ST_ARB
    } state_t;

    state_t           state;
    logic [REC_W-1:0] rec_cnt;   // consecutive recessive bits while integrating
    logic [2:0]       same_cnt;  // run length of equal bits on the wire
    logic             last_bit;  // previous wire bit inside ARB
    logic [3:0]       fld_idx;   // de-stuffed bit index after SOF
    logic [10:0]      id_sr;     // identifier shift register, ID10 enters first
    logic             rtr_sr;    // RTR captured ahead of the IDE decision

    // Derived combinational terms, kept separate for readability.
    logic is_stuff_slot;
    logic run_continues;
    logic rec_done;

    assign is_stuff_slot = (same_cnt == STUFF_RUN);
    assign run_continues = (rx_bit == last_bit);
    assign rec_done      = (rec_cnt == REC_W'(IDLE_BITS - 1));

    // -------------------------------------------------------------------------
    // Single sequential process: state machine, field capture and all
    // registered outputs.
    // NOTE: every register here uses non-blocking assignment so all updates
    // within one edge see the pre-edge values of the other registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INTEGRATE;
            rec_cnt     <= '0;
            same_cnt    <= '0;
            last_bit    <= 1'b1;
            fld_idx     <= '0;
            id_sr       <= '0;
            rtr_sr      <= 1'b0;
            id_out      <= '0;
            rtr_out     <= 1'b0;
            id_valid    <= 1'b0;
            ext_frame   <= 1'b0;
            stuff_err   <= 1'b0;
            bus_idle    <= 1'b0;
            frame_count <= '0;
        end else begin
            // Pulses default low every clock so each lasts exactly one cycle,
            // whether or not the next cycle carries a strobe.
            id_valid  <= 1'b0;
            ext_frame <= 1'b0;
            stuff_err <= 1'b0;

            if (bit_strobe) begin
                case (state)
                    // Wait for IDLE_BITS recessive bits in a row; any
                    // dominant bit restarts the count.
                    ST_INTEGRATE: begin
                        if (rx_bit) begin
                            if (rec_done) begin
                                state    <= ST_IDLE;
                                bus_idle <= 1'b1;
                                rec_cnt  <= '0;
                            end else begin
                                rec_cnt <= rec_cnt + REC_W'(1);
                            end
                        end else begin
                            rec_cnt <= '0;
                        end
                    end

                    // Dominant bit on an idle bus is SOF; it is the first
                    // bit of the stuffing run.
                    ST_IDLE: begin
                        if (!rx_bit) begin
                            state    <= ST_ARB;
                            bus_idle <= 1'b0;
                            same_cnt <= 3'd1;
                            last_bit <= 1'b0;
                            fld_idx  <= '0;
                        end
                    end

                    ST_ARB: begin
                        if (is_stuff_slot) begin
                            // Stuff bit must differ from the run it breaks.
                            if (run_continues) begin
                                stuff_err <= 1'b1;
                                state     <= ST_INTEGRATE;
                                rec_cnt   <= '0;
                            end else begin
                                // Discarded, but it starts a new run.
                                same_cnt <= 3'd1;
                                last_bit <= rx_bit;
                            end
                        end else begin
                            same_cnt <= run_continues ? same_cnt + 3'd1 : 3'd1;
                            last_bit <= rx_bit;
                            fld_idx  <= fld_idx + 4'd1;

                            if (fld_idx <= FLD_ID_LAST) begin
                                id_sr <= {id_sr[9:0], rx_bit};
                            end else if (fld_idx == FLD_RTR) begin
                                rtr_sr <= rx_bit;
                            end else begin
                                // IDE bit closes the arbitration field.
                                if (!rx_bit) begin
                                    id_out      <= id_sr;
                                    rtr_out     <= rtr_sr;
                                    id_valid    <= 1'b1;
                                    frame_count <= frame_count + CNT_W'(1);
                                end else begin
                                    ext_frame <= 1'b1;
                                end
                                state   <= ST_INTEGRATE;
                                rec_cnt <= '0;
                            end
                        end
                    end

                    default: begin
                        state    <= ST_INTEGRATE;
                        rec_cnt  <= '0;
                        bus_idle <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_id_extractor.sv
// -----------------------------------------------------------------------------
// tb_can_id_extractor
//
// Scoreboard bench. Stimulus builds each frame from its fields (SOF, ID, RTR,
// IDE), stuffs it arithmetically, optionally corrupts one stuff bit, and pushes
// the expected outcome into a queue. An independent monitor pops an entry for
// every pulse the DUT presents and compares kind, id_out, rtr_out and
// frame_count. CNT_W is reduced so the counter wraps within the run.
// -----------------------------------------------------------------------------
module tb_can_id_extractor;

    localparam int IDLE_BITS = 11;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_strobe;
    logic             rx_bit;
    logic [10:0]      id_out;
    logic             rtr_out;
    logic             id_valid;
    logic             ext_frame;
    logic             stuff_err;
    logic             bus_idle;
    logic [CNT_W-1:0] frame_count;

    can_id_extractor #(
        .IDLE_BITS (IDLE_BITS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_strobe  (bit_strobe),
        .rx_bit      (rx_bit),
        .id_out      (id_out),
        .rtr_out     (rtr_out),
        .id_valid    (id_valid),
        .ext_frame   (ext_frame),
        .stuff_err   (stuff_err),
        .bus_idle    (bus_idle),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef enum {EV_ID, EV_EXT, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t         kind;
        logic [10:0]      id;
        logic             rtr;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    ev_t              exp_q[$];
    ev_t              mon_e;
    logic             prev_pulse;
    logic [10:0]      m_id;
    logic             m_rtr;
    logic [CNT_W-1:0] m_cnt;
    int               total = 0;
    int               bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] kind_bits(input ev_kind_t k);
        case (k)
            EV_ID:   return 3'b100;
            EV_EXT:  return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // Records the expected outcome; only an accepted base frame changes the
    // held identifier and the counter.
    task automatic push_ev(input ev_kind_t k, input logic [10:0] id, input logic rtr);
        ev_t e;
        if (k == EV_ID) begin
            m_id  = id;
            m_rtr = rtr;
            m_cnt = m_cnt + 1'b1;
        end
        e.kind = k;
        e.id   = m_id;
        e.rtr  = m_rtr;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
    endtask

    // -------------------------------------------------------------- monitor
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_pulse = 1'b0;
        end else if (id_valid || ext_frame || stuff_err) begin
            check("pulse_follows_strobe", {31'd0, bit_strobe}, 32'd1);
            check("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, id_valid, ext_frame, stuff_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {29'd0, id_valid, ext_frame, stuff_err},
                      {29'd0, kind_bits(mon_e.kind)});
                check("id_out", {21'd0, id_out}, {21'd0, mon_e.id});
                check("rtr_out", {31'd0, rtr_out}, {31'd0, mon_e.rtr});
                check("frame_count", {28'd0, frame_count}, {28'd0, mon_e.cnt});
            end
            prev_pulse = 1'b1;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic send_bit(input logic b);
        int gap;
        gap = $urandom_range(0, 2);
        @(negedge clk);
        bit_strobe = 1'b1;
        rx_bit     = b;
        if (gap > 0) begin
            @(negedge clk);
            bit_strobe = 1'b0;
            rx_bit     = 1'($urandom);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    // Drop the strobe; by return every sent bit has been clocked in.
    task automatic settle();
        @(negedge clk);
        bit_strobe = 1'b0;
        rx_bit     = 1'($urandom);
    endtask

    task automatic send_bits(input bit q[$]);
        foreach (q[i]) send_bit(q[i]);
    endtask

    // Wire image of SOF..IDE with a complement bit after every run of five.
    task automatic build_wire(input logic [10:0] id, input logic rtr, input logic ide,
                              output bit w[$], output int stuff_pos[$]);
        bit d[$];
        int run;
        bit prev;
        d = {};
        d.push_back(1'b0);
        for (int i = 10; i >= 0; i--) d.push_back(id[i]);
        d.push_back(rtr);
        d.push_back(ide);
        w         = {};
        stuff_pos = {};
        run       = 0;
        prev      = 1'b1;
        for (int i = 0; i < d.size(); i++) begin
            w.push_back(d[i]);
            run  = (d[i] == prev) ? run + 1 : 1;
            prev = d[i];
            if (run == 5 && i < d.size() - 1) begin
                stuff_pos.push_back(w.size());
                w.push_back(!prev);
                prev = !prev;
                run  = 1;
            end
        end
    endtask

    // Rest-of-frame junk ending dominant, then exactly IDLE_BITS recessive;
    // idle must appear on the last of them and not before.
    task automatic tail_and_idle();
        int n;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) send_bit((i == n - 1) ? 1'b0 : 1'($urandom));
        for (int i = 0; i < IDLE_BITS - 1; i++) send_bit(1'b1);
        settle();
        check("bus_idle_low_before_eof", {31'd0, bus_idle}, 32'd0);
        send_bit(1'b1);
        settle();
        check("bus_idle_after_eof", {31'd0, bus_idle}, 32'd1);
    endtask

    task automatic send_frame(input logic [10:0] id, input logic rtr, input logic ide,
                              input bit inject);
        bit w[$];
        int sp[$];
        int p;
        build_wire(id, rtr, ide, w, sp);
        if (inject && sp.size() > 0) begin
            p    = sp[$urandom_range(0, sp.size() - 1)];
            w[p] = !w[p];
            push_ev(EV_ERR, id, rtr);
        end else if (ide) begin
            push_ev(EV_EXT, id, rtr);
        end else begin
            push_ev(EV_ID, id, rtr);
        end
        check("bus_idle_before_sof", {31'd0, bus_idle}, 32'd1);
        send_bits(w);
        tail_and_idle();
    endtask

    task automatic random_frame();
        logic [10:0] id;
        id = $urandom_range(0, 1) ? (11'h7FF >> $urandom_range(0, 10)) : 11'($urandom);
        if ($urandom_range(0, 1) == 0) id = ~id;
        send_frame(id, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_id_out"},      {21'd0, id_out},      32'd0);
        check({tag, "_rtr_out"},     {31'd0, rtr_out},     32'd0);
        check({tag, "_pulses"},      {29'd0, id_valid, ext_frame, stuff_err}, 32'd0);
        check({tag, "_bus_idle"},    {31'd0, bus_idle},    32'd0);
        check({tag, "_frame_count"}, {28'd0, frame_count}, 32'd0);
    endtask

    // ----------------------------------------------------------- watchdog
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not complete, expected entries left=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        bit w[$];
        int sp[$];

        rst        = 1'b1;
        bit_strobe = 1'b0;
        rx_bit     = 1'b1;
        m_id       = '0;
        m_rtr      = 1'b0;
        m_cnt      = '0;
        prev_pulse = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle detection boundary: dominant at the last-but-one count restarts.
        for (int i = 0; i < IDLE_BITS - 1; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < IDLE_BITS - 1; i++) send_bit(1'b1);
        settle();
        check("bus_idle_after_restart", {31'd0, bus_idle}, 32'd0);
        send_bit(1'b1);
        settle();
        check("bus_idle_after_full_run", {31'd0, bus_idle}, 32'd1);

        // Directed frames.
        send_frame(11'h123, 1'b0, 1'b0, 1'b0);
        send_frame(11'h7F0, 1'b0, 1'b1, 1'b0);
        send_frame(11'h000, 1'b0, 1'b0, 1'b0);

        // Six dominant bits right after idle.
        check("bus_idle_before_six_dom", {31'd0, bus_idle}, 32'd1);
        push_ev(EV_ERR, 11'h000, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        tail_and_idle();

        send_frame(11'h5A5, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) random_frame();

        // Reset in the middle of the identifier: SOF plus six ID bits.
        build_wire(11'h555, 1'b0, 1'b0, w, sp);
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        @(negedge clk);
        rst        = 1'b1;
        bit_strobe = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (2) @(negedge clk);
        check("no_pending_after_reset", exp_q.size(), 32'd0);
        m_id  = '0;
        m_rtr = 1'b0;
        m_cnt = '0;
        rst   = 1'b0;
        for (int i = 0; i < IDLE_BITS; i++) send_bit(1'b1);
        settle();
        check("bus_idle_after_reintegration", {31'd0, bus_idle}, 32'd1);
        send_frame(11'h555, 1'b0, 1'b0, 1'b0);

        // Enough traffic for the narrowed counter to wrap.
        for (int n = 0; n < 45; n++) random_frame();

        repeat (4) settle();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
